// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD card response path: state encoding,
// response lengths, start-bit window default and R1 status bit positions.
package sd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHunt  = 2'd1,
        StShift = 2'd2,
        StFin   = 2'd3
    } sd_resp_state_e;

    localparam int unsigned SD_R1_LEN  = 8;
    localparam int unsigned SD_R7_LEN  = 40;
    localparam int unsigned SD_NCR_MAX = 64;

    localparam int unsigned R1_IDLE_BIT        = 0;
    localparam int unsigned R1_ILLEGAL_CMD_BIT = 2;
    localparam int unsigned R1_CRC_ERR_BIT     = 3;

    // Bit 7 is the start bit and bit 0 only reports the idle state, so neither is an error.
    function automatic logic r1_err_of(input logic [7:0] r1);
        logic [7:0] m;
        m              = r1;
        m[7]           = 1'b0;
        m[R1_IDLE_BIT] = 1'b0;
        return |m;
    endfunction

endpackage

// File: rtl/sd_resp_receiver.sv
// SPI-mode SD response receiver: hunts for the start bit on MISO within the
// N_CR window, then captures an R1 (8-bit) or R3/R7 (40-bit) response.
module sd_resp_receiver
    import sd_pkg::*;
#(
    parameter int unsigned NCR_MAX = SD_NCR_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        resp_long,
    input  logic        sample_en,
    input  logic        miso,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [39:0] resp,
    output logic        r1_err
);

    localparam int unsigned HUNT_W = $clog2(NCR_MAX + 1);

    sd_resp_state_e    state_q, state_d;
    logic [39:0]       resp_q, resp_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
    logic              resp_long_q, resp_long_d;
    logic              timeout_q, timeout_d;
    logic              r1_err_q, r1_err_d;
    logic [5:0]        bit_target;

    assign bit_target = resp_long_q ? 6'(SD_R7_LEN) : 6'(SD_R1_LEN);

    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        bit_cnt_d   = bit_cnt_q;
        hunt_cnt_d  = hunt_cnt_q;
        resp_long_d = resp_long_q;
        timeout_d   = timeout_q;
        r1_err_d    = r1_err_q;

        case (state_q)
            StIdle: begin
                // A strobe in the arming cycle is deliberately not counted.
                if (start) begin
                    resp_long_d = resp_long;
                    resp_d      = '0;
                    bit_cnt_d   = '0;
                    hunt_cnt_d  = '0;
                    timeout_d   = 1'b0;
                    r1_err_d    = 1'b0;
                    state_d     = StHunt;
                end
            end
            StHunt: begin
                if (sample_en) begin
                    // The zero is checked first so a start bit on the last strobe still wins.
                    if (!miso) begin
                        resp_d    = {resp_q[38:0], 1'b0};
                        bit_cnt_d = 6'd1;
                        state_d   = StShift;
                    end else begin
                        hunt_cnt_d = hunt_cnt_q + 1'b1;
                        if (hunt_cnt_d == HUNT_W'(NCR_MAX)) begin
                            timeout_d = 1'b1;
                            state_d   = StFin;
                        end
                    end
                end
            end
            StShift: begin
                if (sample_en) begin
                    resp_d    = {resp_q[38:0], miso};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_d == bit_target) begin
                        r1_err_d = r1_err_of(resp_long_q ? resp_d[39:32] : resp_d[7:0]);
                        state_d  = StFin;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            resp_q      <= '0;
            bit_cnt_q   <= '0;
            hunt_cnt_q  <= '0;
            resp_long_q <= 1'b0;
            timeout_q   <= 1'b0;
            r1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            bit_cnt_q   <= bit_cnt_d;
            hunt_cnt_q  <= hunt_cnt_d;
            resp_long_q <= resp_long_d;
            timeout_q   <= timeout_d;
            r1_err_q    <= r1_err_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StFin);
    assign timeout = timeout_q;
    assign resp    = resp_q;
    assign r1_err  = r1_err_q;

endmodule

// File: tb/tb_sd_resp_receiver.sv
// Directed self-checking bench for sd_resp_receiver: short/long responses,
// timeout boundary, R1 errors, mid-response reset, stray start and strobe gaps.
module tb_sd_resp_receiver;
    import sd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        resp_long = 1'b0;
    logic        sample_en = 1'b0;
    logic        miso = 1'b1;
    logic        busy, done, timeout, r1_err;
    logic [39:0] resp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sd_resp_receiver #(
        .NCR_MAX(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .resp_long(resp_long),
        .sample_en(sample_en),
        .miso     (miso),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .resp     (resp),
        .r1_err   (r1_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Arms a reception and streams hunt-ones followed by the response bits MSB first.
    // done_at is the 1-based strobe after which done was seen (0 = never, >1000 = in a gap).
    task automatic do_resp(input logic lng, input int hunt, input logic [39:0] data,
                           input bit gaps, input int dup_at,
                           output int done_at, output logic busy_after);
        int len;
        len     = lng ? 40 : 8;
        done_at = 0;
        start     = 1'b1;
        resp_long = lng;
        sample_en = gaps;
        miso      = 1'b0;
        cycle();
        start     = 1'b0;
        sample_en = 1'b0;
        miso      = 1'b1;
        for (int i = 0; i < hunt + len; i++) begin
            sample_en = 1'b1;
            miso      = (i < hunt) ? 1'b1 : data[len - 1 - (i - hunt)];
            if (i == dup_at) begin
                start     = 1'b1;
                resp_long = ~lng;
            end
            cycle();
            sample_en = 1'b0;
            start     = 1'b0;
            miso      = 1'b1;
            if (done === 1'b1) begin
                done_at = i + 1;
                break;
            end
            for (int g = 0; g < (gaps ? i % 8 : 0); g++) begin
                cycle();
                if (done === 1'b1 && done_at == 0) done_at = 1000 + i;
            end
            if (done_at != 0) break;
        end
        for (int w = 0; w < 4 && done_at == 0; w++) begin
            cycle();
            if (done === 1'b1) done_at = 2000 + w;
        end
        cycle();
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_tests++; if (r1_err !== 1'b0) begin n_fail++; $display("FAIL reset_r1_err: got %b want 0", r1_err); end
        n_tests++; if (resp !== 40'h0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", resp); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_short_r1();
        int   d;
        logic b;
        do_resp(1'b0, 3, 40'h01, 1'b0, -1, d, b);
        n_tests++; if (d !== 11) begin n_fail++; $display("FAIL short_done_strobe: got %0d want 11", d); end
        n_tests++; if (resp !== 40'h01) begin n_fail++; $display("FAIL short_resp: got %h want 01", resp); end
        n_tests++; if (r1_err !== 1'b0) begin n_fail++; $display("FAIL short_r1_err: got %b want 0", r1_err); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL short_timeout: got %b want 0", timeout); end
        n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL short_busy_after: got %b want 0", b); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL short_done_width: got %b want 0", done); end
    endtask

    task automatic test_long_r7();
        int   d;
        logic b;
        do_resp(1'b1, 2, 40'h01000001AA, 1'b0, -1, d, b);
        n_tests++; if (d !== 42) begin n_fail++; $display("FAIL long_done_strobe: got %0d want 42", d); end
        n_tests++; if (resp !== 40'h01000001AA) begin n_fail++; $display("FAIL long_resp: got %h want 01000001aa", resp); end
        n_tests++; if (r1_err !== 1'b0) begin n_fail++; $display("FAIL long_r1_err: got %b want 0", r1_err); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL long_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_timeout();
        int         d;
        logic       b;
        logic [7:0] crc;
        do_resp(1'b0, 80, 40'h00, 1'b0, -1, d, b);
        n_tests++; if (d !== 64) begin n_fail++; $display("FAIL timeout_strobe: got %0d want 64", d); end
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", timeout); end
        n_tests++; if (resp !== 40'h0) begin n_fail++; $display("FAIL timeout_resp: got %h want 0", resp); end
        n_tests++; if (r1_err !== 1'b0) begin n_fail++; $display("FAIL timeout_r1_err: got %b want 0", r1_err); end
        // Start bit on the very last strobe of the window.
        crc = 8'h01 | (8'h01 << R1_CRC_ERR_BIT);
        do_resp(1'b0, 63, {32'h0, crc}, 1'b0, -1, d, b);
        n_tests++; if (d !== 71) begin n_fail++; $display("FAIL edge_done_strobe: got %0d want 71", d); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL edge_timeout: got %b want 0", timeout); end
        n_tests++; if (resp !== 40'h09) begin n_fail++; $display("FAIL edge_resp: got %h want 09", resp); end
        n_tests++; if (r1_err !== 1'b1) begin n_fail++; $display("FAIL edge_r1_err: got %b want 1", r1_err); end
    endtask

    task automatic test_error_r1();
        int         d;
        logic       b;
        logic [7:0] ill;
        ill = 8'h01 | (8'h01 << R1_ILLEGAL_CMD_BIT);
        do_resp(1'b0, 0, {32'h0, ill}, 1'b0, -1, d, b);
        n_tests++; if (d !== 8) begin n_fail++; $display("FAIL err_done_strobe: got %0d want 8", d); end
        n_tests++; if (resp !== 40'h05) begin n_fail++; $display("FAIL err_resp: got %h want 05", resp); end
        n_tests++; if (r1_err !== 1'b1) begin n_fail++; $display("FAIL err_r1_err: got %b want 1", r1_err); end
        // Idle bit alone is not an error; R1 sits in the top byte of a long response.
        do_resp(1'b1, 1, 40'h3F12345678, 1'b0, -1, d, b);
        n_tests++; if (d !== 41) begin n_fail++; $display("FAIL err_long_strobe: got %0d want 41", d); end
        n_tests++; if (r1_err !== 1'b1) begin n_fail++; $display("FAIL err_long_r1_err: got %b want 1", r1_err); end
        n_tests++; if (resp !== 40'h3F12345678) begin n_fail++; $display("FAIL err_long_resp: got %h want 3f12345678", resp); end
    endtask

    task automatic test_reset_mid_shift();
        logic [39:0] data;
        int          n_done;
        int          d;
        logic        b;
        data      = 40'h01000001AA;
        start     = 1'b1;
        resp_long = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            sample_en = 1'b1;
            miso      = (i == 0) ? 1'b1 : data[39 - (i - 1)];
            cycle();
        end
        sample_en = 1'b0;
        rst       = 1'b1;
        cycle();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_tests++; if (resp !== 40'h0) begin n_fail++; $display("FAIL rst_mid_resp: got %h want 0", resp); end
        n_done = 0;
        for (int i = 0; i < 24; i++) begin
            sample_en = i[0];
            miso      = 1'b0;
            cycle();
            if (done === 1'b1) n_done++;
        end
        sample_en = 1'b0;
        miso      = 1'b1;
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", n_done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got busy %b want 0", busy); end
        do_resp(1'b1, 0, 40'h01000001AA, 1'b0, -1, d, b);
        n_tests++; if (d !== 40) begin n_fail++; $display("FAIL rst_fresh_strobe: got %0d want 40", d); end
        n_tests++; if (resp !== 40'h01000001AA) begin n_fail++; $display("FAIL rst_fresh_resp: got %h want 01000001aa", resp); end
    endtask

    task automatic test_back_to_back();
        int   d;
        logic b;
        // Stray start mid-response, strobe with the arming start, and 0-7 cycle gaps.
        do_resp(1'b0, 3, 40'h05, 1'b1, 5, d, b);
        n_tests++; if (d !== 11) begin n_fail++; $display("FAIL b2b_done_strobe: got %0d want 11", d); end
        n_tests++; if (resp !== 40'h05) begin n_fail++; $display("FAIL b2b_resp: got %h want 05", resp); end
        n_tests++; if (r1_err !== 1'b1) begin n_fail++; $display("FAIL b2b_r1_err: got %b want 1", r1_err); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b want 0", timeout); end
        n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b want 0", b); end
        do_resp(1'b1, 2, 40'h01000001AA, 1'b1, 30, d, b);
        n_tests++; if (d !== 42) begin n_fail++; $display("FAIL b2b_long_strobe: got %0d want 42", d); end
        n_tests++; if (resp !== 40'h01000001AA) begin n_fail++; $display("FAIL b2b_long_resp: got %h want 01000001aa", resp); end
    endtask

    initial begin
        test_reset();
        test_short_r1();
        test_long_r7();
        test_timeout();
        test_error_r1();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_resp_receiver.md
# sd_resp_receiver

SPI-mode SD card response receiver: the receive-side counterpart of the command shifter that drives the card's DI line. After a command has been shifted out, it samples the card's DO (MISO) line, finds the response start bit within the N_CR window, and captures an R1 (8-bit) or R3/R7 (40-bit) response. It reports completion or timeout to the SD init/read controller.

## Interface
- `NCR_MAX`, 64: maximum sample strobes spent hunting for the start bit before timeout (8 bytes).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms reception; accepted only in IDLE.
- `resp_long`  in  1  latched on an accepted `start`: 0 = R1 (8 bits), 1 = R3/R7 (40 bits).
- `sample_en`  in  1  one-cycle strobe at each SCLK rising edge; MISO is valid in that cycle.
- `miso`  in  1  card data out.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of reception or timeout.
- `timeout`  out  1  valid with `done`; held until the next accepted `start`.
- `resp`  out  40  captured response, right-aligned; R1 occupies [7:0] for short and [39:32] for long.
- `r1_err`  out  1  OR of R1 bits 6:1; held with `resp`.

## Operation
- States: IDLE, HUNT, SHIFT, FIN.
- IDLE: `start` latches `resp_long`, clears `resp`, `timeout`, `r1_err` and the counters, then moves to HUNT. `start` in any other state is ignored.
- HUNT, on each `sample_en`:
  - `miso`=0 is the start bit, which is R1 bit 7 (always 0). Shift it into `resp` and go to SHIFT with bit count 1.
  - `miso`=1 increments the hunt counter. When the counter reaches `NCR_MAX`, set `timeout`=1, leave `resp`=0 and go to FIN.
- SHIFT: on each `sample_en`, `resp <= {resp[38:0], miso}` and the bit count increments. When the count reaches 8 (short) or 40 (long), go to FIN.
  - The counter is 6 bits. The compare is exact, with no wrap.
  - `r1_err` is computed from the R1 byte when FIN is entered.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Cycles without `sample_en` hold all state.
- `rst` is honoured in any state, including mid-SHIFT. It forces IDLE and clears `busy`, `done`, `timeout`, `r1_err`, `resp` and all counters.

## Timing
- Reset values: `busy`=0, `done`=0, `timeout`=0, `r1_err`=0, `resp`=0.
- `busy` rises the cycle after `start` and falls in the cycle after the `done` pulse.
- `done` is asserted one cycle after the `sample_en` that captured the last bit or reached the timeout count.
- `resp`, `timeout` and `r1_err` are stable from the `done` cycle until the next accepted `start`.
- A `sample_en` coincident with an accepted `start` is ignored; the first counted sample is the next strobe.
- A `sample_en` arriving during FIN is ignored.
- Start-bit window: at most `NCR_MAX` strobes with MISO high. If the start bit arrives on strobe `NCR_MAX`, no timeout occurs: the strobe count includes the start-bit strobe, and the zero is checked before the timeout compare.
- Total strobes to `done` (short) = hunt strobes + 8.

## Structure
- Shared package `sd_pkg` holds:
  - state encoding (2 bits, 4 states);
  - `SD_R1_LEN`=8 and `SD_R7_LEN`=40;
  - `NCR_MAX` default;
  - R1 bit positions (idle=0, illegal_cmd=2, crc_err=3).
- Single module with no sub-modules. The shift register, bit counter and hunt counter live inline.

## Test plan
- Short R1: `start`, `resp_long`=0; MISO high for 3 strobes, then bits 0000_0001 → `done` 11 strobes after arming, `resp[7:0]`=0x01, `r1_err`=0, `timeout`=0.
- Long R7: `resp_long`=1; after 2 idle strobes, send 0x01_000001AA → `resp`=0x01000001AA and `done` one cycle after the 40th data strobe.
- Timeout: MISO held high → after exactly 64 strobes, `done`=1 with `timeout`=1 and `resp`=0. Also drive the start bit on strobe 64 → no timeout.
- Error R1: bits 0000_0101 (illegal command) → `resp[7:0]`=0x05, `r1_err`=1.
- `rst` asserted at bit 20 of a long response → next cycle `busy`=0 and `resp`=0, and no `done` pulse. A fresh `start` then completes normally.
- `start` pulsed while busy, plus `sample_en` gaps of 0–7 cycles between strobes → second `start` ignored, result identical to the gap-free run.
